// File: rtl/halut_decoder.sv
// halut_decoder: accumulates one LUT entry per codebook from incoming (c,k) codes
// and emits a signed sum after every C accepted codes.
module halut_decoder #(
    parameter int K             = 16,
    parameter int C             = 32,
    parameter int DataTypeWidth = 16,
    parameter int TreeDepth     = $clog2(K),
    parameter int CAddrWidth    = $clog2(C),
    parameter int LutAddrWidth  = CAddrWidth + TreeDepth,
    parameter int AccWidth      = DataTypeWidth + CAddrWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [CAddrWidth-1:0]    c_addr_i,
    input  logic [TreeDepth-1:0]     k_addr_i,
    input  logic                     valid_i,
    input  logic                     decoder_i,
    input  logic [LutAddrWidth-1:0]  waddr_i,
    input  logic [DataTypeWidth-1:0] wdata_i,
    input  logic                     we_i,
    output logic [AccWidth-1:0]      result_o,
    output logic                     valid_o,
    output logic                     busy_o
);
    logic [DataTypeWidth-1:0] lut [C*K];
    logic [CAddrWidth-1:0]    c_q, cnt;
    logic [TreeDepth-1:0]     k_q;
    logic                     v_q;
    logic [DataTypeWidth-1:0] rd;
    logic [AccWidth-1:0]      acc, entry, sum;
    logic                     last;

    // LUT is deliberately left out of reset; a same-edge write is seen by reads only afterwards
    always_ff @(posedge clk_i) begin
        if (we_i) lut[waddr_i] <= wdata_i;
    end

    assign rd     = lut[{c_q, k_q}];
    assign entry  = {{CAddrWidth{rd[DataTypeWidth-1]}}, rd};
    assign sum    = acc + entry;
    assign last   = cnt == CAddrWidth'(C - 1);
    assign busy_o = (cnt != '0) | v_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_q      <= '0;
            k_q      <= '0;
            v_q      <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            result_o <= '0;
            valid_o  <= 1'b0;
        end else if (decoder_i) begin
            v_q     <= valid_i;
            valid_o <= 1'b0;
            if (valid_i) begin
                c_q <= c_addr_i;
                k_q <= k_addr_i;
            end
            if (v_q) begin
                cnt <= last ? '0 : cnt + 1'b1;
                acc <= last ? '0 : sum;
                if (last) begin
                    result_o <= sum;
                    valid_o  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_halut_decoder.sv
// tb_halut_decoder: directed vectors for halut_decoder with hand-computed sums.
module tb_halut_decoder;
    localparam int K  = 16;
    localparam int C  = 32;
    localparam int CW = 5;
    localparam int TD = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [CW-1:0] c_addr_i = '0;
    logic [TD-1:0] k_addr_i = '0;
    logic          valid_i = 1'b0;
    logic          decoder_i = 1'b1;
    logic [8:0]    waddr_i = '0;
    logic [15:0]   wdata_i = '0;
    logic          we_i = 1'b0;
    logic [20:0]   result_o;
    logic          valid_o;
    logic          busy_o;

    halut_decoder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .c_addr_i(c_addr_i), .k_addr_i(k_addr_i),
        .valid_i(valid_i), .decoder_i(decoder_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .we_i(we_i), .result_o(result_o), .valid_o(valid_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [20:0] res_q[$];
    int          cyc_q[$];

    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        if (valid_o) begin
            pulses <= pulses + 1;
            res_q.push_back(result_o);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int addr, input logic [15:0] d);
        waddr_i = 9'(addr);
        wdata_i = d;
        we_i = 1'b1;
        tick();
        we_i = 1'b0;
    endtask

    task automatic send(input int c, input int k);
        c_addr_i = CW'(c);
        k_addr_i = TD'(k);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic send_row(input int kfix);
        for (int c = 0; c < C; c++) send(c, kfix < 0 ? c % K : kfix);
    endtask

    task automatic finish_row(input string tag, input logic [31:0] exp);
        tick();
        tick();
        exp_pulses++;
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
        check({tag, "_result"}, 32'(result_o), exp);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        #2;
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // all ones, exact latency
        for (int a = 0; a < C * K; a++) wr(a, 16'd1);
        send(0, 0);
        check("t1_busy_mid", 32'(busy_o), 32'd1);
        for (int c = 1; c < C; c++) send(c, 0);
        check("t1_lat_pre", 32'(valid_o), 32'd0);
        tick();
        check("t1_lat_pulse", 32'(valid_o), 32'd1);
        check("t1_result", 32'(result_o), 32'd32);
        tick();
        check("t1_lat_post", 32'(valid_o), 32'd0);
        check("t1_busy_post", 32'(busy_o), 32'd0);
        exp_pulses = 1;
        check("t1_pulses", 32'(pulses), 32'd1);

        // c*16+k, k = c%16
        for (int a = 0; a < C * K; a++) wr(a, 16'(a));
        send_row(-1);
        finish_row("t2", 32'd8176);

        // most negative entries
        for (int a = 0; a < C * K; a++) wr(a, 16'h8000);
        send_row(0);
        finish_row("t3", 32'h100000);

        // back-to-back rows: k=0 -> 1, k=1 -> 2
        for (int c = 0; c < C; c++) begin
            wr(c * K, 16'd1);
            wr(c * K + 1, 16'd2);
        end
        idx = pulses;
        send_row(0);
        send_row(1);
        tick();
        tick();
        exp_pulses += 2;
        check("t4_pulses", 32'(pulses), 32'(exp_pulses));
        check("t4_res_a", 32'(res_q[idx]), 32'd32);
        check("t4_res_b", 32'(res_q[idx+1]), 32'd64);
        check("t4_gap", 32'(cyc_q[idx+1] - cyc_q[idx]), 32'd32);

        // write {5,3} during the cycle stage 2 reads it
        for (int c = 0; c < C; c++) wr(c * K + 3, 16'd7);
        for (int c = 0; c < C; c++) begin
            if (c == 6) begin
                waddr_i = 9'(5 * K + 3);
                wdata_i = 16'd100;
                we_i = 1'b1;
            end
            send(c, 3);
            we_i = 1'b0;
        end
        finish_row("t5_old", 32'd224);
        send_row(3);
        finish_row("t5_new", 32'd317);

        // freeze for 5 cycles after code 10 while valid_i toggles
        for (int c = 0; c <= 10; c++) send(c, 3);
        decoder_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c_addr_i = CW'(i);
            k_addr_i = '0;
            valid_i = (i % 2) == 0;
            tick();
        end
        valid_i = 1'b0;
        check("t6_busy_frozen", 32'(busy_o), 32'd1);
        check("t6_no_pulse", 32'(pulses), 32'(exp_pulses));
        decoder_i = 1'b1;
        for (int c = 11; c < C; c++) send(c, 3);
        finish_row("t6_gated", 32'd317);

        // reset mid-row discards the partial sum
        for (int c = 0; c <= 20; c++) send(c, 3);
        rst_ni = 1'b0;
        #2;
        check("t7_rst_result", 32'(result_o), 32'd0);
        check("t7_rst_valid", 32'(valid_o), 32'd0);
        check("t7_rst_busy", 32'(busy_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        send_row(3);
        finish_row("t7_fresh", 32'd317);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
